// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: D-stage stall/forward unit backed by a shift scoreboard of in-flight writers
// Ports: clk, reset_n (sync, active low); d_valid, d_rs/d_rt + d_tuse_rs/rt, d_wa + d_tnew describe
// the D-stage instruction; d_md_use/d_md_start/d_md_div describe mult/div traffic.
// Outputs: stall, fwd_rs_sel/fwd_rt_sel (0 = GRF, k+1 = scoreboard entry k), md_busy.
// Optional mult/div busy tracking is compiled in with HAZARD_MD_EN.
module hazard_scoreboard #(
  parameter int NSTAGE  = 3,
  parameter int TW      = 2,
  parameter int AW      = 5,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          d_valid,
  input  logic [AW-1:0]                 d_rs,
  input  logic [AW-1:0]                 d_rt,
  input  logic [TW-1:0]                 d_tuse_rs,
  input  logic [TW-1:0]                 d_tuse_rt,
  input  logic [AW-1:0]                 d_wa,
  input  logic [TW-1:0]                 d_tnew,
  input  logic                          d_md_use,
  input  logic                          d_md_start,
  input  logic                          d_md_div,
  output logic                          stall,
  output logic [$clog2(NSTAGE+1)-1:0]   fwd_rs_sel,
  output logic [$clog2(NSTAGE+1)-1:0]   fwd_rt_sel,
  output logic                          md_busy
);
  localparam int SW = $clog2(NSTAGE + 1);
  logic [AW-1:0] wa_q [NSTAGE];
  logic [AW-1:0] wa_d [NSTAGE];
  logic [TW-1:0] tnew_q [NSTAGE];
  logic [TW-1:0] tnew_d [NSTAGE];
  logic          hit_rs, hit_rt, stall_rs, stall_rt, md_stall;
  logic [SW-1:0] sel_rs, sel_rt;
  logic [TW-1:0] tn_rs, tn_rt;
  // Scanning oldest to youngest lets the youngest match overwrite older ones.
  always_comb begin
    hit_rs = 1'b0;
    hit_rt = 1'b0;
    sel_rs = '0;
    sel_rt = '0;
    tn_rs  = '0;
    tn_rt  = '0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (d_rs != '0 && wa_q[k] == d_rs) begin
        hit_rs = 1'b1;
        sel_rs = SW'(k + 1);
        tn_rs  = tnew_q[k];
      end
      if (d_rt != '0 && wa_q[k] == d_rt) begin
        hit_rt = 1'b1;
        sel_rt = SW'(k + 1);
        tn_rt  = tnew_q[k];
      end
    end
  end
  assign stall_rs   = d_valid && d_tuse_rs != '1 && hit_rs && tn_rs > d_tuse_rs;
  assign stall_rt   = d_valid && d_tuse_rt != '1 && hit_rt && tn_rt > d_tuse_rt;
  assign stall      = stall_rs | stall_rt | md_stall;
  assign fwd_rs_sel = (hit_rs && tn_rs == '0) ? sel_rs : '0;
  assign fwd_rt_sel = (hit_rt && tn_rt == '0) ? sel_rt : '0;
  always_comb begin
    wa_d[0]   = (d_valid && !stall) ? d_wa : '0;
    tnew_d[0] = (d_valid && !stall) ? d_tnew : '0;
    for (int k = 1; k < NSTAGE; k++) begin
      wa_d[k]   = wa_q[k-1];
      tnew_d[k] = tnew_q[k-1] - TW'(tnew_q[k-1] != '0);
    end
  end
  always_ff @(posedge clk) begin
    for (int k = 0; k < NSTAGE; k++) begin
      wa_q[k]   <= reset_n ? wa_d[k] : '0;
      tnew_q[k] <= reset_n ? tnew_d[k] : '0;
    end
  end
`ifdef HAZARD_MD_EN
  localparam int CW = $clog2(DIV_LAT + 1);
  logic [CW-1:0] md_cnt_q, md_cnt_d;
  assign md_busy  = md_cnt_q != '0;
  assign md_stall = d_valid & d_md_use & md_busy;
  // A start while busy is itself stalled, so it can never reload a running count.
  always_comb begin
    md_cnt_d = (d_valid && d_md_start && !stall) ? (d_md_div ? CW'(DIV_LAT) : CW'(MUL_LAT))
                                                 : md_cnt_q - CW'(md_busy);
  end
  always_ff @(posedge clk) begin
    md_cnt_q <= reset_n ? md_cnt_d : '0;
  end
`else
  logic unused_md;
  assign unused_md = ^{d_md_use, d_md_start, d_md_div, MUL_LAT[0], DIV_LAT[0]};
  assign md_busy   = 1'b0;
  assign md_stall  = 1'b0;
`endif
endmodule
